// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction ROM address and captures its output into the IF/ID register.
// Define FETCH_COUNT_EN to add the saturating fetch_count output.
`timescale 1ns/1ps

module instruction_fetch #(
    parameter logic [15:0] RESET_PC    = 16'd1,
    parameter logic [4:0]  HALT_OPCODE = 5'b11010,
    parameter logic [8:0]  NOP_WORD    = 9'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [8:0]  instruction,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [8:0]  if_instr,
    output logic [15:0] if_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {
        FETCHING = 1'b0,
        HALTED   = 1'b1
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [15:0] pc_next;
    logic        valid_next;
    logic [8:0]  instr_next;
    logic [15:0] if_pc_next;
    logic        load;
    logic        is_halt;
    logic        capture;

    assign load    = !if_valid || id_ready;
    assign is_halt = (instruction[8:4] == HALT_OPCODE);
    assign halted  = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCHING;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
            if_pc    <= 16'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            if_valid <= valid_next;
            if_instr <= instr_next;
            if_pc    <= if_pc_next;
        end
    end

    // Redirect beats halt, halt beats capture; anything left over is a stall that holds everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_valid;
        instr_next = if_instr;
        if_pc_next = if_pc;
        capture    = 1'b0;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            instr_next = NOP_WORD;
            state_next = FETCHING;
        end else if (state == HALTED) begin
            if (id_ready) begin
                valid_next = 1'b0;
            end
        end else if (load) begin
            capture    = 1'b1;
            instr_next = instruction;
            if_pc_next = pc;
            valid_next = 1'b1;
            if (is_halt) begin
                state_next = HALTED;
            end else begin
                pc_next = pc + 16'd1;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else if (capture && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus queues expected IF/ID transfers,
// a negedge monitor pops them whenever decode accepts an entry.
`timescale 1ns/1ps

module tb_instruction_fetch;

    typedef struct {
        logic [15:0] pc;
        logic [8:0]  instr;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [8:0]  instruction;
    logic        id_ready;
    logic        if_valid;
    logic [8:0]  if_instr;
    logic [15:0] if_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        halt_en;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    xfer_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .instruction   (instruction),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM returns the low address bits, except a halt word planted at address 39.
    assign instruction = (halt_en && pc == 16'd39) ? 9'h1A0 : pc[8:0];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic rv, input logic [15:0] rpc);
        id_ready       = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic expectTransfer(input logic [15:0] xpc, input logic [8:0] xinstr);
        xfer_t e;
        e.pc    = xpc;
        e.instr = xinstr;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"}, 32'(pc), 32'd1);
        checkOutput({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        checkOutput({tag, "_if_instr"}, 32'(if_instr), 32'd0);
        checkOutput({tag, "_if_pc"}, 32'(if_pc), 32'd0);
        checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    // Monitor: an entry is consumed when valid and ready meet at the coming edge without a redirect.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_xfer: got pc 0x%0h instr 0x%0h, expected no transfer at %0t",
                         if_pc, if_instr, $time);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                checkOutput("xfer_pc", 32'(if_pc), 32'(e.pc));
                checkOutput("xfer_instr", 32'(if_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        halt_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0);
        step();
        checkResetState("reset0");

        applyStimulus(1'b1, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) expectTransfer(16'(k), 9'(k));

        step();
        checkOutput("first_valid", 32'(if_valid), 32'd1);
        checkOutput("first_if_pc", 32'(if_pc), 32'd1);
        checkOutput("first_instr", 32'(if_instr), 32'd1);
        checkOutput("first_pc", 32'(pc), 32'd2);
        repeat (4) step();
        checkOutput("seq_if_pc", 32'(if_pc), 32'd5);
        checkOutput("seq_pc", 32'(pc), 32'd6);

        applyStimulus(1'b0, 1'b0, 16'd0);
        repeat (3) begin
            step();
            checkOutput("stall_pc", 32'(pc), 32'd6);
            checkOutput("stall_if_pc", 32'(if_pc), 32'd5);
            checkOutput("stall_instr", 32'(if_instr), 32'd5);
            checkOutput("stall_valid", 32'(if_valid), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 16'd0);
        step();
        checkOutput("resume_if_pc", 32'(if_pc), 32'd6);
        checkOutput("resume_pc", 32'(pc), 32'd7);
        repeat (2) step();
        checkOutput("pre_redir_if_pc", 32'(if_pc), 32'd8);

        applyStimulus(1'b0, 1'b1, 16'd14);
        step();
        checkOutput("redir_valid", 32'(if_valid), 32'd0);
        checkOutput("redir_pc", 32'(pc), 32'd14);
        applyStimulus(1'b1, 1'b0, 16'd0);
        halt_en = 1'b1;
        for (int k = 14; k <= 38; k++) expectTransfer(16'(k), 9'(k));
        expectTransfer(16'd39, 9'h1A0);
        step();
        checkOutput("post_redir_if_pc", 32'(if_pc), 32'd14);
        checkOutput("post_redir_valid", 32'(if_valid), 32'd1);

        repeat (25) step();
        checkOutput("halt_if_pc", 32'(if_pc), 32'd39);
        checkOutput("halt_instr", 32'(if_instr), 32'h1A0);
        checkOutput("halt_flag", 32'(halted), 32'd1);
        checkOutput("halt_valid", 32'(if_valid), 32'd1);
        checkOutput("halt_pc", 32'(pc), 32'd39);
        repeat (10) begin
            step();
            checkOutput("halted_pc", 32'(pc), 32'd39);
            checkOutput("halted_flag", 32'(halted), 32'd1);
            checkOutput("halted_valid", 32'(if_valid), 32'd0);
        end

        applyStimulus(1'b1, 1'b1, 16'd26);
        step();
        checkOutput("unhalt_flag", 32'(halted), 32'd0);
        checkOutput("unhalt_pc", 32'(pc), 32'd26);
        checkOutput("unhalt_valid", 32'(if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        halt_en = 1'b0;
        expectTransfer(16'd26, 9'd26);
        step();
        checkOutput("resume26_if_pc", 32'(if_pc), 32'd26);
        checkOutput("resume26_pc", 32'(pc), 32'd27);
        step();
        checkOutput("resume27_if_pc", 32'(if_pc), 32'd27);
        checkOutput("resume27_pc", 32'(pc), 32'd28);

        applyStimulus(1'b0, 1'b1, 16'hFFFF);
        step();
        checkOutput("wrap_redir_pc", 32'(pc), 32'hFFFF);
        checkOutput("wrap_redir_valid", 32'(if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        expectTransfer(16'hFFFF, 9'h1FF);
        expectTransfer(16'h0000, 9'h000);
        step();
        checkOutput("wrap_if_pc", 32'(if_pc), 32'hFFFF);
        checkOutput("wrap_instr", 32'(if_instr), 32'h1FF);
        checkOutput("wrap_pc", 32'(pc), 32'h0000);
        step();
        checkOutput("wrap0_if_pc", 32'(if_pc), 32'h0000);
        checkOutput("wrap0_pc", 32'(pc), 32'd1);

        // Reset lands between edges to prove it does not wait for the clock.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
`ifdef FETCH_COUNT_EN
        checkOutput("count_reset", fetch_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) expectTransfer(16'(k), 9'(k));
        repeat (5) step();
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("rerun_if_pc", 32'(if_pc), 32'd5);
        checkOutput("rerun_pc", 32'(pc), 32'd6);
`ifdef FETCH_COUNT_EN
        checkOutput("count_five", fetch_count, 32'd5);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("final_reset");
`ifdef FETCH_COUNT_EN
        checkOutput("count_cleared", fetch_count, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
